// File: rtl/wam_game_fsm_pkg.sv
// Shared encodings and defaults for the whack-a-mole game sequencer.
package wam_pkg;

    typedef enum logic [2:0] {
        S_SETUP     = 3'd0,
        S_WAIT      = 3'd1,
        S_PLAY      = 3'd2,
        S_GAME_OVER = 3'd3,
        S_RESTART   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'd0,
        MODE_TIMED      = 2'd1,
        MODE_LIVES      = 2'd2,
        MODE_NORMAL_ALT = 2'd3
    } mode_t;

    localparam int NORMAL_HITS_DEF   = 25;
    localparam int EXTENDED_HITS_DEF = 50;

endpackage

// File: rtl/wam_game_fsm_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clock cycles.
module wam_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, wrapping on the tick cycle; clear restarts the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/wam_game_fsm.sv
// Game sequencer: start/restart flow, ready countdown, scoring and end-of-game detection.
module wam_game_fsm
    import wam_pkg::*;
#(
    parameter int N_LIGHTS      = 9,
    parameter int POS_W         = 4,
    parameter int SCORE_W       = 7,
    parameter int TICK_DIV      = 50_000_000,
    parameter int READY_SECS    = 6,
    parameter int GAME_SECS     = 60,
    parameter int LIVES         = 3,
    parameter int NORMAL_HITS   = NORMAL_HITS_DEF,
    parameter int EXTENDED_HITS = EXTENDED_HITS_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic [1:0]                     mode,
    input  logic                           extended,
    input  logic                           light_on,
    input  logic                           light_off,
    input  logic [POS_W-1:0]               light_pos,
    input  logic                           key_valid,
    input  logic [POS_W-1:0]               key_pos,
    output logic [2:0]                     state,
    output logic                           flick_en,
    output logic                           clear_n,
    output logic                           tick,
    output logic [2:0]                     ready_count,
    output logic [SCORE_W-1:0]             score,
    output logic [SCORE_W-1:0]             max_hits,
    output logic [SCORE_W-1:0]             lights_done,
    output logic [$clog2(GAME_SECS+1)-1:0] time_left,
    output logic [1:0]                     lives_left,
    output logic                           game_over
);

    localparam int TIME_W = $clog2(GAME_SECS + 1);

    state_t           state_q;
    mode_t            mode_q;
    logic             play_q;
    logic             active;
    logic             hit;
    logic [POS_W-1:0] pos_q;

    logic       play_rise;
    logic       key_ok;
    logic       key_hit;
    logic       key_miss;
    logic       hit_after;
    logic       off_miss;
    logic       active_after_off;
    logic       on_miss;
    logic [1:0] miss_cnt;
    logic [1:0] lives_next;
    logic       is_timed;
    logic       is_lives;
    logic       timed_end;
    logic       budget_end;
    logic       lives_end;
    logic       prescale_en;
    logic       prescale_clr;

    assign play_rise = play && !play_q;
    assign is_timed  = (mode_q == MODE_TIMED);
    assign is_lives  = (mode_q == MODE_LIVES);

    assign prescale_en  = (state_q == S_WAIT) || (state_q == S_PLAY);
    assign prescale_clr = (state_q == S_RESTART);

    wam_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (prescale_en),
        .clear  (prescale_clr),
        .tick   (tick)
    );

    // Resolve same-cycle events in key, light_off, light_on order; keys beyond the last lamp are not real keys.
    always_comb begin
        key_ok           = key_valid && ({1'b0, key_pos} < (POS_W+1)'(N_LIGHTS));
        key_hit          = key_ok && active && !hit && (key_pos == pos_q);
        key_miss         = key_ok && active && (key_pos != pos_q);
        hit_after        = hit || key_hit;
        off_miss         = light_off && active && !hit_after;
        active_after_off = active && !light_off;
        on_miss          = light_on && active_after_off && !hit_after;
        miss_cnt         = 2'(key_miss) + 2'(off_miss) + 2'(on_miss);
        lives_next       = (lives_left > miss_cnt) ? (lives_left - miss_cnt) : 2'd0;
        timed_end        = is_timed && tick && (time_left == TIME_W'(1));
        budget_end       = !is_timed && light_off && (lights_done == max_hits);
        lives_end        = is_lives && (miss_cnt != 2'd0) && (lives_left <= miss_cnt);
    end

    // Main sequencer: play_rise overrides everything, RESTART reloads, PLAY scores and detects the end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SETUP;
            mode_q      <= MODE_NORMAL;
            play_q      <= 1'b0;
            active      <= 1'b0;
            hit         <= 1'b0;
            pos_q       <= '0;
            ready_count <= 3'(READY_SECS);
            score       <= '0;
            max_hits    <= SCORE_W'(NORMAL_HITS);
            lights_done <= '0;
            time_left   <= TIME_W'(GAME_SECS);
            lives_left  <= 2'(LIVES);
        end else begin
            play_q <= play;
            if (play_rise && (state_q != S_RESTART)) begin
                state_q <= S_RESTART;
            end else begin
                case (state_q)
                    S_RESTART: begin
                        mode_q      <= mode_t'(mode);
                        max_hits    <= extended ? SCORE_W'(EXTENDED_HITS) : SCORE_W'(NORMAL_HITS);
                        active      <= 1'b0;
                        hit         <= 1'b0;
                        ready_count <= 3'(READY_SECS);
                        score       <= '0;
                        lights_done <= '0;
                        time_left   <= TIME_W'(GAME_SECS);
                        lives_left  <= 2'(LIVES);
                        state_q     <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (tick) begin
                            if (ready_count == 3'd1) begin
                                ready_count <= 3'd0;
                                state_q     <= S_PLAY;
                            end else begin
                                ready_count <= ready_count - 3'd1;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (key_hit && (score != '1)) begin
                            score <= score + 1'b1;
                        end
                        if (is_lives) begin
                            lives_left <= lives_next;
                        end
                        if (light_on) begin
                            if (lights_done != '1) begin
                                lights_done <= lights_done + 1'b1;
                            end
                            active <= 1'b1;
                            hit    <= 1'b0;
                            pos_q  <= light_pos;
                        end else begin
                            active <= active_after_off;
                            hit    <= hit_after;
                        end
                        if (is_timed && tick) begin
                            time_left <= (time_left == TIME_W'(1)) ? '0 : time_left - 1'b1;
                        end
                        if (timed_end || budget_end || lives_end) begin
                            state_q <= S_GAME_OVER;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign flick_en  = (state_q == S_PLAY);
    assign clear_n   = (state_q != S_RESTART);
    assign game_over = (state_q == S_GAME_OVER);

endmodule
